// File: rtl/part_1_init_rcv_if.sv
`default_nettype none
// ============================================================================
// Module   : part_1_init_rcv_if
// Brief    : Pin bundle between the init receiver, the mission clock sources,
//            the transport get channel and the partition payload pins.
// Revision : 1.0 - initial release
// ============================================================================
interface part_1_init_rcv_if;
   // Mission clock levels, one per channel
   logic       clk_0_h;
   logic       clk_1_h;
   logic       clk_2_h;
   logic       clk_3_h;
   // Mission clock block / release
   logic [3:0] freeze_clk;
   // Transport get channel
   logic       get_req;
   logic [1:0] get_clk_id;
   logic       get_ack;
   logic [8:0] get_data;
   // Partition payload pins, channels 0..3
   logic       wen0;
   logic [7:0] i_data0;
   logic       wen1;
   logic [7:0] i_data1;
   logic       wen2;
   logic [7:0] i_data2;
   logic       valid;
   logic [7:0] o_data;
   // Status
   logic       err_o;
   logic       busy_o;

   // Receiver side: issues get requests and drives the partition pins
   modport master (
      input  clk_0_h, clk_1_h, clk_2_h, clk_3_h,
      input  get_ack, get_data,
      output freeze_clk, get_req, get_clk_id,
      output wen0, i_data0, wen1, i_data1, wen2, i_data2, valid, o_data,
      output err_o, busy_o
   );

   // Environment side: clock sources, transport responder, partition pins
   modport slave (
      output clk_0_h, clk_1_h, clk_2_h, clk_3_h,
      output get_ack, get_data,
      input  freeze_clk, get_req, get_clk_id,
      input  wen0, i_data0, wen1, i_data1, wen2, i_data2, valid, o_data,
      input  err_o, busy_o
   );
endinterface
`default_nettype wire

// File: rtl/part_1_init_rcv.sv
`default_nettype none
// ============================================================================
// Module   : part_1_init_rcv
// Brief    : Detects rising edges on four mission clocks, freezes them, fetches
//            one payload per edged channel over the get channel (lowest index
//            first, watchdog protected), then releases the clocks after a
//            stretch period.
// Revision : 1.0 - initial release
// ============================================================================
module part_1_init_rcv #(
   parameter int unsigned STRETCH  = 2,    // 1..15
   parameter int unsigned WATCHDOG = 1000  // 2..65535
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   part_1_init_rcv_if.master bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      REQ  = 2'd2,
      HOLD = 2'd3
   } state_t;

   localparam logic [15:0] WD_LAST      = 16'(WATCHDOG - 1);
   localparam logic [3:0]  STRETCH_LAST = 4'(STRETCH - 1);

   state_t          state_q, state_d;
   logic [3:0]      pending_q, pending_d;
   logic [3:0]      freeze_q, freeze_d;
   logic [3:0]      prev_q, prev_d;
   logic            first_q, first_d;
   logic            get_req_q, get_req_d;
   logic [1:0]      id_q, id_d;
   logic [15:0]     wd_q, wd_d;
   logic [3:0]      st_q, st_d;
   logic            err_q, err_d;
   logic [3:0]      wen_q, wen_d;
   logic [3:0][7:0] data_q, data_d;

   logic [3:0]      lvl;
   logic [3:0]      edges;
   logic [1:0]      lowest;

   assign lvl = {bus.clk_3_h, bus.clk_2_h, bus.clk_1_h, bus.clk_0_h};

   // Edge detect: level history only tracks while the clocks are released,
   // and the first cycle out of reset just loads the history.
   always_comb begin
      prev_d  = (freeze_q == 4'h0) ? lvl : prev_q;
      first_d = 1'b0;
      edges   = 4'h0;
      if ((freeze_q == 4'h0) && !first_q) begin
         edges = lvl & ~prev_q;
      end
   end

   // Next state, request sequencing, watchdog, stretch and payload capture
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      freeze_d  = freeze_q;
      get_req_d = get_req_q;
      id_d      = id_q;
      wd_d      = wd_q;
      st_d      = st_q;
      err_d     = err_q;
      wen_d     = wen_q;
      data_d    = data_q;

      if (pending_q[0]) begin
         lowest = 2'd0;
      end else if (pending_q[1]) begin
         lowest = 2'd1;
      end else if (pending_q[2]) begin
         lowest = 2'd2;
      end else begin
         lowest = 2'd3;
      end

      case (state_q)
         IDLE: begin
            if (edges != 4'h0) begin
               pending_d = edges;
               freeze_d  = 4'hF;
               state_d   = SCAN;
            end
         end
         SCAN: begin
            if (pending_q != 4'h0) begin
               id_d      = lowest;
               get_req_d = 1'b1;
               wd_d      = 16'd0;
               state_d   = REQ;
            end else begin
               st_d    = 4'd0;
               state_d = HOLD;
            end
         end
         REQ: begin
            // An acknowledge on the expiry cycle still delivers its payload
            if (get_req_q && bus.get_ack) begin
               wen_d[id_q]     = bus.get_data[8];
               data_d[id_q]    = bus.get_data[7:0];
               pending_d[id_q] = 1'b0;
               get_req_d       = 1'b0;
               state_d         = SCAN;
            end else if (wd_q == WD_LAST) begin
               err_d           = 1'b1;
               pending_d[id_q] = 1'b0;
               get_req_d       = 1'b0;
               state_d         = SCAN;
            end else begin
               wd_d = wd_q + 16'd1;
            end
         end
         HOLD: begin
            if (st_q == STRETCH_LAST) begin
               freeze_d = 4'h0;
               state_d  = IDLE;
            end else begin
               st_d = st_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= IDLE;
         pending_q <= 4'h0;
         freeze_q  <= 4'h0;
         prev_q    <= 4'h0;
         first_q   <= 1'b1;
         get_req_q <= 1'b0;
         id_q      <= 2'd0;
         wd_q      <= 16'd0;
         st_q      <= 4'd0;
         err_q     <= 1'b0;
         wen_q     <= 4'h0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         freeze_q  <= freeze_d;
         prev_q    <= prev_d;
         first_q   <= first_d;
         get_req_q <= get_req_d;
         id_q      <= id_d;
         wd_q      <= wd_d;
         st_q      <= st_d;
         err_q     <= err_d;
         wen_q     <= wen_d;
         data_q    <= data_d;
      end
   end

   assign bus.freeze_clk = freeze_q;
   assign bus.get_req    = get_req_q;
   assign bus.get_clk_id = id_q;
   assign bus.wen0       = wen_q[0];
   assign bus.i_data0    = data_q[0];
   assign bus.wen1       = wen_q[1];
   assign bus.i_data1    = data_q[1];
   assign bus.wen2       = wen_q[2];
   assign bus.i_data2    = data_q[2];
   assign bus.valid      = wen_q[3];
   assign bus.o_data     = data_q[3];
   assign bus.err_o      = err_q;
   assign bus.busy_o     = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_part_1_init_rcv.sv
`default_nettype none
// ============================================================================
// Module   : tb_part_1_init_rcv
// Brief    : Randomized bench for part_1_init_rcv. Stimulus plans each freeze
//            window as a list of transactions; a responder answers the get
//            channel from that plan and a monitor scores the DUT against a
//            transaction-level model of the expected behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_part_1_init_rcv;

   localparam int unsigned STRETCH  = 2;
   localparam int unsigned WATCHDOG = 16;
   localparam int unsigned N_WIN    = 40;

   typedef struct {
      int unsigned id;
      logic [8:0]  data;
      bit          to;
      int unsigned dly;
   } item_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   part_1_init_rcv_if bus ();

   part_1_init_rcv #(.STRETCH(STRETCH), .WATCHDOG(WATCHDOG)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   item_t exp_q[$];
   item_t resp_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   bit    mon_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [8:0] chan_out(input int k);
      case (k)
         0:       return {bus.wen0, bus.i_data0};
         1:       return {bus.wen1, bus.i_data1};
         2:       return {bus.wen2, bus.i_data2};
         default: return {bus.valid, bus.o_data};
      endcase
   endfunction

   task automatic set_levels(input logic [3:0] m);
      bus.clk_0_h = m[0];
      bus.clk_1_h = m[1];
      bus.clk_2_h = m[2];
      bus.clk_3_h = m[3];
   endtask

   task automatic plan(input int unsigned id, input logic [8:0] data,
                       input int unsigned dly, input bit to);
      item_t it;
      it.id = id; it.data = data; it.dly = dly; it.to = to;
      exp_q.push_back(it);
      resp_q.push_back(it);
   endtask

   // Raise the given clock levels, then keep toggling inputs only while a
   // request is outstanding (clocks certainly frozen) until the window ends.
   task automatic fire(input logic [3:0] mask);
      int unsigned guard;
      @(negedge clk);
      set_levels(mask);
      @(negedge clk);
      #1;
      chk("edge_to_freeze", 32'(bus.freeze_clk), 32'hF);
      guard = 0;
      while (bus.busy_o && guard < 600) begin
         if (bus.get_req) set_levels(4'($urandom));
         else             set_levels(4'h0);
         @(negedge clk);
         #1;
         guard++;
      end
      if (guard >= 600) chk("window_timeout", 32'd0, 32'd1);
      set_levels(4'h0);
      repeat (2) @(negedge clk);
   endtask

   // Transport responder: acks per plan, scatters ignored acks when idle
   bit          r_active = 1'b0;
   int unsigned r_cnt    = 0;
   item_t       r_cur;
   initial begin : responder
      bus.get_ack  = 1'b0;
      bus.get_data = 9'h0;
      forever begin
         @(negedge clk);
         if (bus.get_req === 1'b1) begin
            if (!r_active) begin
               if (resp_q.size() == 0) r_cur.to = 1'b1;
               else                    r_cur = resp_q.pop_front();
               r_active = 1'b1;
               r_cnt    = 0;
            end
            if (!r_cur.to && r_cnt == r_cur.dly) begin
               bus.get_ack  = 1'b1;
               bus.get_data = r_cur.data;
            end else begin
               bus.get_ack  = 1'b0;
               bus.get_data = 9'($urandom);
            end
            r_cnt++;
         end else begin
            r_active     = 1'b0;
            bus.get_ack  = ($urandom_range(0, 3) == 0);
            bus.get_data = 9'($urandom);
         end
      end
   end

   // Monitor / scoreboard
   logic [8:0]  m_model [4];
   bit          m_err, m_prev_req, m_first, m_have, m_acc, m_upd;
   logic [3:0]  m_prev_frz;
   int unsigned m_obs = 0, m_rise, m_fall, m_hi, m_upd_id;
   logic [8:0]  m_upd_data;
   item_t       m_cur;
   initial begin : monitor
      forever begin
         @(negedge clk);
         #1;
         m_obs++;
         if (!mon_en) begin
            for (int k = 0; k < 4; k++) m_model[k] = 9'h0;
            m_err = 0; m_prev_req = 0; m_prev_frz = 4'h0; m_first = 0;
            m_have = 0; m_acc = 0; m_upd = 0; m_fall = 0; m_rise = 0; m_hi = 0;
            continue;
         end
         if (m_upd) begin
            m_model[m_upd_id] = m_upd_data;
            m_upd = 0;
         end
         if (m_prev_frz == 4'h0 && bus.freeze_clk == 4'hF) begin
            m_rise  = m_obs;
            m_first = 1;
         end
         if (m_prev_frz == 4'hF && bus.freeze_clk == 4'h0)
            chk("hold_len", m_obs - m_fall, STRETCH + 1);
         chk("freeze_vs_busy", 32'(bus.freeze_clk), 32'({4{bus.busy_o}}));
         if (bus.get_req && !m_prev_req) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_req", 32'd1, 32'd0);
               m_have = 0;
            end else begin
               m_cur  = exp_q.pop_front();
               m_have = 1;
               chk("req_latency", m_obs, (m_first ? m_rise : m_fall) + 1);
            end
            m_first = 0;
            m_hi    = 0;
         end
         if (bus.get_req) begin
            m_hi++;
            if (m_have) chk("req_id", 32'(bus.get_clk_id), m_cur.id);
            if (bus.get_ack) begin
               m_upd      = 1;
               m_upd_id   = m_have ? m_cur.id : 32'(bus.get_clk_id);
               m_upd_data = m_have ? m_cur.data : bus.get_data;
               m_acc      = 1;
            end
         end
         if (!bus.get_req && m_prev_req) begin
            m_fall = m_obs;
            if (m_have) chk("req_outcome_acked", 32'(m_acc), 32'(!m_cur.to));
            if (!m_acc) begin
               chk("watchdog_len", m_hi, WATCHDOG);
               m_err = 1;
            end
            m_acc  = 0;
            m_have = 0;
         end
         chk("err_o", 32'(bus.err_o), 32'(m_err));
         for (int k = 0; k < 4; k++)
            chk($sformatf("chan%0d", k), 32'(chan_out(k)), 32'(m_model[k]));
         m_prev_req = bus.get_req;
         m_prev_frz = bus.freeze_clk;
      end
   end

   initial begin : global_timeout
      #2000000;
      $display("FAIL global_timeout: got stuck, required completion");
      $fatal(1, "simulation time limit");
   end

   initial begin : stimulus
      logic [3:0]  mask;
      int unsigned guard;
      set_levels(4'h0);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_freeze", 32'(bus.freeze_clk), 32'h0);
      chk("rst_get_req", 32'(bus.get_req), 32'h0);
      chk("rst_id", 32'(bus.get_clk_id), 32'h0);
      chk("rst_err", 32'(bus.err_o), 32'h0);
      chk("rst_busy", 32'(bus.busy_o), 32'h0);
      for (int k = 0; k < 4; k++) chk($sformatf("rst_chan%0d", k), 32'(chan_out(k)), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      // Single channel, one-cycle ack
      plan(1, 9'h155, 0, 0);
      fire(4'b0010);
      // Two simultaneous channels in one window
      plan(0, 9'h1AA, 0, 0);
      plan(3, 9'h1C3, 1, 0);
      fire(4'b1001);
      // Never acknowledged
      plan(2, 9'h1FF, 0, 1);
      fire(4'b0100);
      // Ack on the watchdog expiry cycle
      plan(1, 9'h0E7, WATCHDOG - 1, 0);
      fire(4'b0010);

      for (int w = 0; w < N_WIN; w++) begin
         mask = 4'($urandom_range(1, 15));
         for (int k = 0; k < 4; k++) begin
            if (mask[k]) begin
               int unsigned r;
               r = $urandom_range(0, 9);
               plan(k, 9'($urandom), (r == 0) ? WATCHDOG - 1 : r % 4,
                    ($urandom_range(0, 9) == 0));
            end
         end
         fire(mask);
      end

      // Reset in the middle of a request
      mon_en = 1'b0;
      begin
         item_t it;
         it.id = 1; it.data = 9'h0; it.dly = 0; it.to = 1'b1;
         resp_q.push_back(it);
      end
      @(negedge clk);
      set_levels(4'b0010);
      guard = 0;
      do begin
         @(negedge clk);
         #1;
         guard++;
      end while (!bus.get_req && guard < 10);
      chk("mid_rst_req_seen", 32'(bus.get_req), 32'd1);
      @(negedge clk);
      set_levels(4'b0001);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      chk("mid_rst_get_req", 32'(bus.get_req), 32'h0);
      chk("mid_rst_freeze", 32'(bus.freeze_clk), 32'h0);
      chk("mid_rst_busy", 32'(bus.busy_o), 32'h0);
      chk("mid_rst_err", 32'(bus.err_o), 32'h0);
      for (int k = 0; k < 4; k++) chk($sformatf("mid_rst_chan%0d", k), 32'(chan_out(k)), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         chk("no_req_after_rst", 32'({bus.get_req, bus.busy_o}), 32'h0);
      end
      set_levels(4'h0);
      repeat (2) @(negedge clk);
      mon_en = 1'b1;
      repeat (2) @(negedge clk);
      plan(0, 9'h13C, 2, 0);
      fire(4'b0001);

      repeat (5) @(negedge clk);
      chk("exp_q_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
